// File: rtl/cfg_frame_pkg.sv
// Shared definitions for the column frame loader.
// Holds the header word layout, the header marker value and the loader
// state encoding used by col_frame_loader and its strobe generator.
package cfg_frame_pkg;

  // Header word layout: [31:28] marker, [27:20] column, [19:15] frame index.
  // Bits [14:0] of a header carry no meaning and are not decoded.
  localparam logic [3:0] HDR_MARKER = 4'hF;
  localparam int HDR_MSB  = 31;
  localparam int HDR_LSB  = 15;
  localparam int HDR_COL_W = 8;
  localparam int HDR_IDX_W = 5;

  typedef struct packed {
    logic [3:0]           marker;
    logic [HDR_COL_W-1:0] col;
    logic [HDR_IDX_W-1:0] idx;
  } hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STROBE,
    HOLD
  } state_t;

endpackage

// File: rtl/col_frame_loader_if.sv
// Configuration word stream into the column frame loader.
//   in_data  : configuration word (header or row data)
//   in_valid : word valid, driven by the source
//   in_ready : loader can accept a word, driven by the loader
// A word moves when in_valid && in_ready in the same cycle.
interface col_frame_loader_if #(
  parameter int FrameBitsPerRow = 32
);
  logic [FrameBitsPerRow-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/frame_strobe_gen.sv
// One-hot frame strobe pulse generator.
// A start pulse latches the frame index; from the next cycle the matching
// strobe bit is high for exactly StrobeWidth cycles. done is high during
// the final strobe cycle so the caller can move on right after it.
//   clk, rst : clock and synchronous active-high reset (cuts a pulse short)
//   start    : begin a pulse train for index
//   index    : frame index, caller guarantees index < MaxFramesPerCol
//   strobe   : one-hot strobe lines
//   done     : last cycle of the pulse train
module frame_strobe_gen
  import cfg_frame_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int StrobeWidth     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [HDR_IDX_W-1:0]       index,
  output logic [MaxFramesPerCol-1:0] strobe,
  output logic                       done
);

  // StrobeWidth is limited to 1..4, so a 2-bit cycle counter suffices.
  localparam logic [1:0] LastCnt = 2'(StrobeWidth - 1);

  logic                 active_q;
  logic [1:0]           cnt_q;
  logic [HDR_IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= index;
    end else if (active_q) begin
      if (cnt_q == LastCnt) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  assign done   = active_q && (cnt_q == LastCnt);
  assign strobe = active_q ? (MaxFramesPerCol'(1) << idx_q) : '0;

endmodule

// File: rtl/col_frame_loader.sv
// Per-column configuration frame loader.
// Takes a header word followed by NumberOfRows data words, assembles the
// column frame in FrameData and, if the header addressed this column with a
// legal frame index, pulses one FrameStrobe line for StrobeWidth cycles and
// then raises frame_done for one cycle.
//   CLK, RST    : configuration clock, synchronous active-high reset
//   MODE        : 1 = configuration, 0 = operation (loader idle)
//   cfg         : word stream (in_data / in_valid / in_ready)
//   FrameData   : column frame data, row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe : one-hot frame latch pulse
//   frame_done  : one-cycle pulse after each strobed frame
//   err, err_clr: sticky protocol error and its clear
module col_frame_loader
  import cfg_frame_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 16,
  parameter int ColumnIndex     = 0,
  parameter int StrobeWidth     = 1
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic                                    MODE,
  col_frame_loader_if.slave                       cfg,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    frame_done,
  output logic                                    err,
  input  logic                                    err_clr
);

  localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);

  state_t               state_q, state_d;
  logic [RowW-1:0]      row_q;
  logic                 col_match_q;
  logic [HDR_IDX_W-1:0] idx_q;
  logic                 err_q;

  hdr_t hdr;
  logic in_ready;
  logic xfer;
  logic last_row;
  logic idx_ok;
  logic strobe_start;
  logic strobe_done;
  logic err_set;

  assign hdr      = hdr_t'(cfg.in_data[HDR_MSB:HDR_LSB]);
  // Held low during reset so no word is taken in the reset cycle.
  assign in_ready = !RST && MODE && ((state_q == IDLE) || (state_q == DATA));
  assign cfg.in_ready = in_ready;
  assign xfer     = cfg.in_valid && in_ready;
  assign last_row = (row_q == LastRow);
  assign idx_ok   = 32'(idx_q) < MaxFramesPerCol;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving DATA on its last word: a matched legal frame strobes, a matched
  // out-of-range index is an error, and a frame for another column is
  // simply finished. Dropping MODE in DATA abandons the partial frame.
  always_comb begin
    state_d      = state_q;
    strobe_start = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr.marker == HDR_MARKER) begin
            state_d = DATA;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      DATA: begin
        if (!MODE) begin
          state_d = IDLE;
        end else if (xfer && last_row) begin
          if (col_match_q && idx_ok) begin
            state_d      = STROBE;
            strobe_start = 1'b1;
          end else begin
            state_d = IDLE;
            err_set = col_match_q;
          end
        end
      end
      STROBE: begin
        if (strobe_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Header capture, row writes and the sticky error flag. Rows are written
  // only in DATA, so FrameData cannot change while a strobe is active.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q       <= '0;
      col_match_q <= 1'b0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      FrameData   <= '0;
    end else begin
      if ((state_q == IDLE) && xfer && (hdr.marker == HDR_MARKER)) begin
        row_q       <= '0;
        col_match_q <= (hdr.col == HDR_COL_W'(ColumnIndex));
        idx_q       <= hdr.idx;
      end
      if ((state_q == DATA) && xfer) begin
        if (col_match_q) begin
          for (int r = 0; r < NumberOfRows; r++) begin
            if (row_q == RowW'(r)) begin
              FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= cfg.in_data;
            end
          end
        end
        if (!last_row) begin
          row_q <= row_q + 1'b1;
        end
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  frame_strobe_gen #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .StrobeWidth    (StrobeWidth)
  ) u_strobe_gen (
    .clk   (CLK),
    .rst   (RST),
    .start (strobe_start),
    .index (idx_q),
    .strobe(FrameStrobe),
    .done  (strobe_done)
  );

  assign frame_done = (state_q == HOLD);
  assign err        = err_q;

endmodule

// File: tb/tb_col_frame_loader.sv
// Testbench for col_frame_loader.
// Two loaders for column 3 are instantiated, one with a single-cycle strobe
// and one with a three-cycle strobe; sel routes the stimulus to one of them.
// A transaction-level reference model (frame buffer, blocked-cycle countdown)
// predicts every output each cycle.
module tb_col_frame_loader;

  localparam int MF  = 20;
  localparam int W   = 32;
  localparam int NR  = 16;
  localparam int COL = 3;
  localparam int CW  = W * NR;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST = 1'b1;
  logic          sel = 1'b0;
  logic          mode_c = 1'b0;
  logic          valid_c = 1'b0;
  logic          err_clr_c = 1'b0;
  logic [W-1:0]  data_c = '0;

  col_frame_loader_if #(.FrameBitsPerRow(W)) bus_a ();
  col_frame_loader_if #(.FrameBitsPerRow(W)) bus_b ();

  logic [CW-1:0] fd_a, fd_b;
  logic [MF-1:0] fs_a, fs_b;
  logic          done_a, done_b, err_a, err_b;

  assign bus_a.in_data  = data_c;
  assign bus_b.in_data  = data_c;
  assign bus_a.in_valid = valid_c && !sel;
  assign bus_b.in_valid = valid_c && sel;

  col_frame_loader #(
    .MaxFramesPerCol(MF), .FrameBitsPerRow(W), .NumberOfRows(NR),
    .ColumnIndex(COL), .StrobeWidth(1)
  ) dut_a (
    .CLK(CLK), .RST(RST), .MODE(mode_c && !sel), .cfg(bus_a),
    .FrameData(fd_a), .FrameStrobe(fs_a), .frame_done(done_a),
    .err(err_a), .err_clr(err_clr_c && !sel)
  );

  col_frame_loader #(
    .MaxFramesPerCol(MF), .FrameBitsPerRow(W), .NumberOfRows(NR),
    .ColumnIndex(COL), .StrobeWidth(3)
  ) dut_b (
    .CLK(CLK), .RST(RST), .MODE(mode_c && sel), .cfg(bus_b),
    .FrameData(fd_b), .FrameStrobe(fs_b), .frame_done(done_b),
    .err(err_b), .err_clr(err_clr_c && sel)
  );

  logic [CW-1:0] obs_fd;
  logic [MF-1:0] obs_fs;
  logic          obs_ready, obs_done, obs_err;

  assign obs_fd    = sel ? fd_b : fd_a;
  assign obs_fs    = sel ? fs_b : fs_a;
  assign obs_ready = sel ? bus_b.in_ready : bus_a.in_ready;
  assign obs_done  = sel ? done_b : done_a;
  assign obs_err   = sel ? err_b : err_a;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_fd [NR];
  bit           m_in_frame;
  int           m_row;
  bit           m_match;
  int           m_idx;
  int           m_blocked;
  int           m_sidx;
  bit           m_err;
  int           m_sw;
  bit           last_xfer;

  task automatic checkOutput(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] modelFrame();
    logic [CW-1:0] f;
    f = '0;
    for (int r = 0; r < NR; r++) f[r*W +: W] = m_fd[r];
    return f;
  endfunction

  task automatic modelReset(input bit s);
    for (int r = 0; r < NR; r++) m_fd[r] = '0;
    m_in_frame = 0;
    m_row = 0;
    m_match = 0;
    m_idx = 0;
    m_blocked = 0;
    m_sidx = 0;
    m_err = 0;
    m_sw = s ? 3 : 1;
  endtask

  // One cycle: drive inputs, compare all outputs against the model, then
  // advance the model across the coming clock edge.
  task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit m, input bit clr);
    bit            exp_ready;
    logic [MF-1:0] exp_fs;
    bit            xfer;
    bit            err_set;
    @(negedge CLK);
    valid_c = v;
    data_c = d;
    mode_c = m;
    err_clr_c = clr;
    #1;
    exp_ready = m && (m_blocked == 0);
    exp_fs = (m_blocked > 1) ? (MF'(1) << m_sidx) : '0;
    checkOutput("in_ready", CW'(obs_ready), CW'(exp_ready));
    checkOutput("FrameStrobe", CW'(obs_fs), CW'(exp_fs));
    checkOutput("frame_done", CW'(obs_done), CW'(m_blocked == 1));
    checkOutput("err", CW'(obs_err), CW'(m_err));
    checkOutput("FrameData", obs_fd, modelFrame());

    xfer = v && exp_ready;
    last_xfer = xfer;
    err_set = 0;
    if (m_blocked > 0) begin
      m_blocked--;
    end else if (m_in_frame) begin
      if (!m) begin
        m_in_frame = 0;
      end else if (xfer) begin
        if (m_match) m_fd[m_row] = d;
        if (m_row == NR - 1) begin
          m_in_frame = 0;
          if (m_match && m_idx < MF) begin
            m_blocked = m_sw + 1;
            m_sidx = m_idx;
          end else if (m_match) begin
            err_set = 1;
          end
        end else begin
          m_row++;
        end
      end
    end else if (xfer) begin
      if (d[31:28] == 4'hF) begin
        m_in_frame = 1;
        m_row = 0;
        m_match = (d[27:20] == 8'(COL));
        m_idx = int'(d[19:15]);
      end else begin
        err_set = 1;
      end
    end
    if (err_set) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic doReset(input bit s);
    @(negedge CLK);
    RST = 1'b1;
    sel = s;
    valid_c = 1'b0;
    mode_c = 1'b1;
    err_clr_c = 1'b0;
    @(negedge CLK);
    #1;
    checkOutput("reset_in_ready", CW'(obs_ready), CW'(0));
    checkOutput("reset_strobe", CW'(obs_fs), CW'(0));
    checkOutput("reset_done", CW'(obs_done), CW'(0));
    checkOutput("reset_err", CW'(obs_err), CW'(0));
    checkOutput("reset_data", obs_fd, CW'(0));
    modelReset(s);
    RST = 1'b0;
  endtask

  // Hold the word valid until the model says it was taken (bounded).
  task automatic sendWord(input logic [W-1:0] d);
    int n;
    n = 0;
    last_xfer = 0;
    while (!last_xfer && n < 40) begin
      applyStimulus(1'b1, d, 1'b1, 1'b0);
      n++;
    end
    checkOutput("word_accepted", CW'(last_xfer), CW'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, $urandom, 1'b1, 1'b0);
  endtask

  task automatic sendFrame(input logic [W-1:0] hdr, input logic [W-1:0] base);
    sendWord(hdr);
    for (int r = 0; r < NR; r++) sendWord(base + W'(r));
  endtask

  task automatic randomFrame();
    logic [7:0]   col;
    logic [4:0]   idx;
    logic [W-1:0] hdr;
    int           abort_at;
    col = ($urandom_range(0, 3) != 0) ? 8'(COL) : 8'($urandom_range(0, 255));
    idx = 5'($urandom_range(0, 23));
    hdr = {4'hF, col, idx, 15'($urandom)};
    if ($urandom_range(0, 9) == 0) hdr[31:28] = 4'($urandom_range(0, 14));
    abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NR - 1) : NR;
    sendWord(hdr);
    if (hdr[31:28] == 4'hF) begin
      for (int r = 0; r < NR; r++) begin
        if (r == abort_at) begin
          applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
          break;
        end
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, $urandom, 1'b1, 1'b0);
        sendWord($urandom);
      end
    end
    repeat ($urandom_range(0, 3)) applyStimulus(1'b0, $urandom, 1'b1, ($urandom_range(0, 3) == 0));
  endtask

  initial begin
    // Single-cycle strobe loader
    doReset(1'b0);
    sendFrame(32'hF032_8000, 32'h1000_0000);
    idle(3);
    sendFrame(32'hF044_8000, 32'h2000_0000);
    idle(2);
    sendFrame(32'hF03A_0000, 32'h3000_0000);
    idle(2);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    idle(1);
    sendWord(32'hA032_8000);
    idle(1);
    sendFrame(32'hF032_8000, 32'h4000_0000);
    idle(3);
    sendWord(32'hF032_8000);
    for (int r = 0; r < 7; r++) sendWord(32'h5000_0000 + W'(r));
    applyStimulus(1'b1, 32'h5000_0007, 1'b0, 1'b0);
    sendFrame(32'hF032_8000, 32'h6000_0000);
    idle(3);

    // Three-cycle strobe loader: back-to-back frames with valid held high
    doReset(1'b1);
    sendFrame(32'hF030_0000, 32'h7000_0000);
    sendFrame(32'hF032_8000, 32'h8000_0000);
    // MODE drops while strobing; the sequence still completes
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    idle(4);
    sendFrame(32'hF039_8000, 32'h9000_0000);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    doReset(1'b1);
    idle(2);

    // Randomized traffic on both loaders
    for (int s = 0; s < 2; s++) begin
      doReset(s[0]);
      for (int f = 0; f < 30; f++) randomFrame();
      idle(5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
